// File: rtl/screen_mem_if.sv
// Bundles the display fetch, CPU write and screen-memory port signals of
// screen_mem_arbiter; slave is the arbiter side, master the surrounding logic.
interface screen_mem_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int PEND_W = 3
);
  logic              fetch_req;
  logic [5:0]        fetch_col;
  logic [4:0]        fetch_row;
  logic [DATA_W-1:0] char_code;
  logic              char_valid;

  logic              cpu_wr_valid;
  logic              cpu_wr_ready;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [PEND_W-1:0] wr_pending;

  modport slave (
    input  fetch_req, fetch_col, fetch_row,
    input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    input  mem_rdata,
    output char_code, char_valid, cpu_wr_ready,
    output mem_addr, mem_we, mem_wdata, wr_pending
  );

  modport master (
    output fetch_req, fetch_col, fetch_row,
    output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    output mem_rdata,
    input  char_code, char_valid, cpu_wr_ready,
    input  mem_addr, mem_we, mem_wdata, wr_pending
  );
endinterface

// File: rtl/screen_mem_arbiter.sv
// Single-port screen memory arbiter: display fetches win every slot, CPU writes
// queue in a FIFO and drain in idle slots. Define SMEM_DEFER_COUNT_EN for defer_count.
module screen_mem_arbiter #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  screen_mem_if.slave bus
`ifdef SMEM_DEFER_COUNT_EN
  ,
  output logic [15:0] defer_count
`endif
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              empty, full, push, pop;

  logic              fetch_in_range;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  // Fetch pipeline stage between the request and the memory read data.
  logic              p1_valid, p1_blank;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);

  assign bus.cpu_wr_ready = !full;
  assign bus.wr_pending   = wr_ptr - rd_ptr;
  assign bus.mem_we       = (state == ST_WRITE);

  // Writes outside the visible screen are acknowledged but dropped.
  assign push = bus.cpu_wr_valid && !full && (32'(bus.cpu_wr_addr) < CELLS);

  always_comb begin
    if (COLS == 40)
      fetch_addr = ADDR_W'((32'(bus.fetch_row) << 5) + (32'(bus.fetch_row) << 3)
                           + 32'(bus.fetch_col));
    else
      fetch_addr = ADDR_W'(32'(bus.fetch_row) * COLS + 32'(bus.fetch_col));
    fetch_in_range = (32'(bus.fetch_col) < COLS) && (32'(bus.fetch_row) < ROWS);
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt     = ST_IDLE;
    mem_addr_nxt  = bus.mem_addr;
    mem_wdata_nxt = bus.mem_wdata;
    pop           = 1'b0;
    if (bus.fetch_req && fetch_in_range) begin
      state_nxt    = ST_READ;
      mem_addr_nxt = fetch_addr;
    end else if (!empty) begin
      state_nxt     = ST_WRITE;
      mem_addr_nxt  = fifo_addr[rd_idx];
      mem_wdata_nxt = fifo_data[rd_idx];
      pop           = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      p1_valid       <= 1'b0;
      p1_blank       <= 1'b0;
      bus.char_valid <= 1'b0;
      bus.char_code  <= '0;
    end else begin
      state          <= state_nxt;
      bus.mem_addr   <= mem_addr_nxt;
      bus.mem_wdata  <= mem_wdata_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      p1_valid       <= bus.fetch_req;
      p1_blank       <= !fetch_in_range;
      bus.char_valid <= p1_valid;
      if (p1_valid)
        bus.char_code <= p1_blank ? '0 : bus.mem_rdata;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_idx] <= bus.cpu_wr_addr;
      fifo_data[wr_idx] <= bus.cpu_wr_data;
    end
  end

`ifdef SMEM_DEFER_COUNT_EN
  // Counts display slots that pushed back a queued write.
  always_ff @(posedge clk) begin
    if (reset)
      defer_count <= '0;
    else if (state == ST_READ && !empty && defer_count != 16'hFFFF)
      defer_count <= defer_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Directed bench for screen_mem_arbiter with an asynchronous-read screen RAM model
// and a log of every memory write. Build with SMEM_DEFER_COUNT_EN to cover defer_count.
module tb_screen_mem_arbiter;

  logic clk;
  logic reset;

  screen_mem_if #(.ADDR_W(11), .DATA_W(8), .PEND_W(3)) bus ();

`ifdef SMEM_DEFER_COUNT_EN
  logic [15:0] defer_count;
`endif

  screen_mem_arbiter #(
    .COLS(40), .ROWS(30), .ADDR_W(11), .DATA_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SMEM_DEFER_COUNT_EN
    ,
    .defer_count (defer_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0]  mem [2048];
  logic [10:0] log_addr [64];
  logic [7:0]  log_data [64];
  int          wr_n = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        if (wr_n < 64) begin
          log_addr[wr_n] = bus.mem_addr;
          log_data[wr_n] = bus.mem_wdata;
        end
        wr_n++;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_req    = 1'b0;
    bus.fetch_col    = '0;
    bus.fetch_row    = '0;
    bus.cpu_wr_valid = 1'b0;
    bus.cpu_wr_addr  = '0;
    bus.cpu_wr_data  = '0;
  endtask

  int  base;
  int  acc;
  logic hs;

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    check("rst_char_code", bus.char_code, 0);
    check("rst_char_valid", bus.char_valid, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_wr_pending", bus.wr_pending, 0);
    reset = 1'b0;
    step();
    check("rst_ready", bus.cpu_wr_ready, 1);

    // Fetch col=3 row=2 -> address 83, RAM holds 83^5A = 09.
    bus.fetch_req = 1'b1; bus.fetch_col = 6'd3; bus.fetch_row = 5'd2;
    step();
    check("fetch_t1_addr", bus.mem_addr, 83);
    check("fetch_t1_we", bus.mem_we, 0);
    check("fetch_t1_valid", bus.char_valid, 0);
    bus.fetch_req = 1'b0;
    step();
    check("fetch_t2_valid", bus.char_valid, 1);
    check("fetch_t2_code", bus.char_code, 8'h09);
    step();
    check("fetch_t3_valid", bus.char_valid, 0);

    // Single CPU write, no fetches.
    base = wr_n;
    bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 11'd100; bus.cpu_wr_data = 8'h41;
    step();
    bus.cpu_wr_valid = 1'b0;
    check("wr1_pending", bus.wr_pending, 1);
    check("wr1_no_bypass", bus.mem_we, 0);
    step();
    check("wr1_we", bus.mem_we, 1);
    check("wr1_addr", bus.mem_addr, 100);
    check("wr1_wdata", bus.mem_wdata, 8'h41);
    check("wr1_pending0", bus.wr_pending, 0);
    step();
    check("wr1_we_done", bus.mem_we, 0);
    check("wr1_logged", wr_n - base, 1);

    // Five writes while fetch_req is held for 10 cycles.
    base = wr_n;
    acc  = 0;
    for (int k = 0; k < 10; k++) begin
      bus.fetch_req = 1'b1; bus.fetch_col = 6'(k); bus.fetch_row = 5'd1;
      bus.cpu_wr_valid = (acc < 5);
      bus.cpu_wr_addr  = 11'(200 + acc);
      bus.cpu_wr_data  = 8'(8'hA0 + acc);
      hs = bus.cpu_wr_valid && bus.cpu_wr_ready;
      step();
      if (hs) acc++;
      check("hold_no_we", bus.mem_we, 0);
    end
    check("hold_accepts", acc, 4);
    check("hold_ready", bus.cpu_wr_ready, 0);
    check("hold_pending", bus.wr_pending, 4);
    check("hold_no_writes", wr_n - base, 0);
    bus.fetch_req = 1'b0;
    for (int k = 0; k < 30 && !(acc == 5 && bus.wr_pending == 0 && !bus.mem_we); k++) begin
      bus.cpu_wr_valid = (acc < 5);
      bus.cpu_wr_addr  = 11'(200 + acc);
      bus.cpu_wr_data  = 8'(8'hA0 + acc);
      hs = bus.cpu_wr_valid && bus.cpu_wr_ready;
      step();
      if (hs) acc++;
    end
    bus.cpu_wr_valid = 1'b0;
    check("drain_accepts", acc, 5);
    check("drain_pending", bus.wr_pending, 0);
    check("drain_count", wr_n - base, 5);
    for (int i = 0; i < 5; i++) begin
      check("drain_order_addr", log_addr[base + i], 200 + i);
      check("drain_order_data", log_data[base + i], 8'hA0 + i);
    end

    // Out-of-range column: no read, blank result.
    bus.fetch_req = 1'b1; bus.fetch_col = 6'd40; bus.fetch_row = 5'd0;
    step();
    bus.fetch_req = 1'b0;
    check("oor_col_no_read", bus.mem_addr, 204);
    step();
    check("oor_col_valid", bus.char_valid, 1);
    check("oor_col_code", bus.char_code, 0);

    // Out-of-range row.
    bus.fetch_req = 1'b1; bus.fetch_col = 6'd0; bus.fetch_row = 5'd30;
    step();
    bus.fetch_req = 1'b0;
    step();
    check("oor_row_valid", bus.char_valid, 1);
    check("oor_row_code", bus.char_code, 0);

    // Write to 1200 is dropped; 1199 is the last legal cell.
    base = wr_n;
    bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 11'd1200; bus.cpu_wr_data = 8'h77;
    check("oor_wr_ready", bus.cpu_wr_ready, 1);
    step();
    bus.cpu_wr_valid = 1'b0;
    check("oor_wr_pending", bus.wr_pending, 0);
    step();
    step();
    check("oor_wr_none", wr_n - base, 0);
    bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 11'd1199; bus.cpu_wr_data = 8'h66;
    step();
    bus.cpu_wr_valid = 1'b0;
    check("edge_wr_pending", bus.wr_pending, 1);
    step();
    check("edge_wr_we", bus.mem_we, 1);
    check("edge_wr_addr", bus.mem_addr, 1199);
    bus.fetch_req = 1'b1; bus.fetch_col = 6'd39; bus.fetch_row = 5'd29;
    step();
    bus.fetch_req = 1'b0;
    check("edge_fetch_addr", bus.mem_addr, 1199);
    step();
    check("edge_fetch_valid", bus.char_valid, 1);
    check("edge_fetch_code", bus.char_code, 8'h66);

    // Reset with 3 queued writes and a read in flight.
    base = wr_n;
    for (int k = 0; k < 3; k++) begin
      bus.fetch_req = 1'b1; bus.fetch_col = 6'd0; bus.fetch_row = 5'd0;
      bus.cpu_wr_valid = 1'b1;
      bus.cpu_wr_addr  = 11'(300 + k);
      bus.cpu_wr_data  = 8'(8'hC0 + k);
      step();
    end
    bus.cpu_wr_valid = 1'b0;
    check("mid_pending3", bus.wr_pending, 3);
    bus.fetch_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_pending0", bus.wr_pending, 0);
    check("mid_valid0", bus.char_valid, 0);
    check("mid_we0", bus.mem_we, 0);
    step();
    check("mid_valid_after", bus.char_valid, 0);
    step();
    step();
    check("mid_no_writes", wr_n - base, 0);

`ifdef SMEM_DEFER_COUNT_EN
    check("defer_reset", defer_count, 0);
    bus.fetch_req = 1'b1; bus.fetch_col = 6'd1; bus.fetch_row = 5'd0;
    bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 11'd400; bus.cpu_wr_data = 8'h11;
    step();
    bus.cpu_wr_addr = 11'd401; bus.cpu_wr_data = 8'h12;
    step();
    bus.cpu_wr_valid = 1'b0;
    step();
    bus.fetch_req = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("defer_count", defer_count, 3);
    check("defer_drained", bus.wr_pending, 0);
`endif

    idle_inputs();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/screen_mem_arbiter.md
Name: screen_mem_arbiter

Overview:
- Shares one single-port character screen memory between the VGA display path (tile fetches) and the CPU (writes).
- Display fetches have absolute priority and fixed 2-cycle latency, so pixel timing is never disturbed.
- CPU writes are buffered in a small FIFO and drained on cycles with no display fetch.
- Sits between vgatimer-driven display logic and the screen RAM.

Parameters:
- COLS, 40, tiles per row
- ROWS, 30, tile rows
- ADDR_W, 11, screen memory address width (must satisfy COLS*ROWS <= 2^ADDR_W)
- DATA_W, 8, character code width
- FIFO_DEPTH, 4, CPU write buffer entries (power of 2, >= 2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  display tile fetch request, single-cycle pulse
- fetch_col  in  6  tile column for fetch_req
- fetch_row  in  5  tile row for fetch_req
- char_code  out  DATA_W  fetched character code
- char_valid  out  1  pulses when char_code is valid
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  FIFO can accept a write
- cpu_wr_addr  in  ADDR_W  linear screen address
- cpu_wr_data  in  DATA_W  character to write
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read issue
- wr_pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values: char_code=0, char_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_pending=0. cpu_wr_ready=1 the cycle after reset deasserts.
- Memory port FSM (registered, one op per cycle):
  - IDLE: no request pending.
  - READ: issue display read.
  - WRITE: drain one FIFO entry.
- Transitions each cycle:
  - fetch_req=1 → READ, regardless of FIFO state.
  - Else if FIFO non-empty → WRITE.
  - Else → IDLE.
- Fetch address: row*COLS + col, computed as (row<<5)+(row<<3) when COLS=40; generic multiply otherwise. Truncate to ADDR_W.
- Fetch latency:
  - Cycle T: fetch_req sampled.
  - Cycle T+1: mem_addr is driven and mem_we=0.
  - Cycle T+2: mem_rdata is registered into char_code and char_valid=1 for exactly one cycle.
  - Back-to-back fetch_req on every cycle is supported, fully pipelined.
- Out-of-range fetch (col>=COLS or row>=ROWS): no read is issued (the slot may drain a write). At T+2, char_valid=1 with char_code=0 (blank).
- CPU handshake:
  - A write transfers when cpu_wr_valid && cpu_wr_ready.
  - cpu_wr_ready = !full. There is no bypass: when full, a same-cycle pop does not allow a push.
  - cpu_wr_addr/data are captured in the FIFO.
  - Addresses >= COLS*ROWS are accepted but discarded: no push, so wr_pending is unchanged.
- Drain: in a WRITE cycle, mem_addr/mem_wdata come from the FIFO head, mem_we=1 for that single cycle, and the head is popped. Writes retire in FIFO order.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged.
- Empty FIFO with a push: the entry is drainable no earlier than the next cycle (no same-cycle bypass to memory).
- Ordering: there is no read-after-write forwarding. A fetch of an address with a pending write returns the old memory contents. This is acceptable; the display refreshes every frame.
- Starvation: continuous fetch_req holds off writes indefinitely. The display side guarantees idle slots (blanking).
- Reset mid-operation:
  - FIFO is flushed and writes in flight are discarded.
  - An in-flight read produces no char_valid.
  - mem_we=0 the cycle after reset is sampled.
- Pointer wrap-around: modulo FIFO_DEPTH. A full/empty distinction uses an extra pointer bit.

Optional Feature:
- Macro: SMEM_DEFER_COUNT_EN.
- Defined:
  - Adds output defer_count (16 bits).
  - Increments on each READ cycle during which the FIFO was non-empty, i.e. a write was deferred.
  - Saturates at 16'hFFFF and clears on reset.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then fetch_req with col=3, row=2 → at T+1 mem_addr=83, mem_we=0; at T+2 char_valid=1 and char_code = memory[83].
- CPU writes addr=100 data=8'h41 with no fetches → next cycle mem_we=1, mem_addr=100, mem_wdata=8'h41; wr_pending returns to 0.
- Five CPU writes back-to-back while fetch_req is held high for 10 cycles → cpu_wr_ready drops after 4 accepts; 5th is held; no mem_we while fetch_req is high; afterwards the writes retire in order, including the 5th.
- fetch_col=40, row=0 → no read issued; at T+2 char_valid=1, char_code=0. CPU write addr=1200 → accepted, wr_pending stays 0, never written.
- Assert reset while FIFO holds 3 entries and a read is in flight → next cycle wr_pending=0, char_valid=0, mem_we=0; no write reaches memory.
- With SMEM_DEFER_COUNT_EN: 2 pending writes plus 3 consecutive fetch_req → defer_count=3.
